// File: rtl/wr_ingress_ctrl_pkg.sv
// Shared constants and types for the write-domain ingress controller.
// Optional drop mode is selected with WR_INGRESS_DROP_EN.
package wr_ingress_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int DROP_CNT_W = 16;

  typedef logic [1:0] skid_cnt_t;

  localparam skid_cnt_t SKID_EMPTY = 2'd0;
  localparam skid_cnt_t SKID_ONE   = 2'd1;
  localparam skid_cnt_t SKID_FULL  = 2'd2;

endpackage

// File: rtl/wr_ingress_ctrl_if.sv
// Producer valid/ready stream into the write ingress controller.
// master = producer, slave = wr_ingress_ctrl.
interface wr_ingress_ctrl_if
  import wr_ingress_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/wr_ingress_ctrl_gray2bin.sv
// Gray-to-binary conversion as a pure XOR prefix.
// Bit i of the result is the XOR of all gray bits from i upward.
module gray2bin #(
  parameter int W = 6
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wr_ingress_ctrl.sv
// Write-domain FIFO front end: 2-entry skid buffer, write qualify, level.
// Define WR_INGRESS_DROP_EN to drop on overflow and count drops.
module wr_ingress_ctrl
  import wr_ingress_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  wr_ingress_ctrl_if.slave      in_if,
  input  logic                  Wr_full,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic [ADDR_WIDTH:0]   sync_read_ptr,
  output logic                  Wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fifo_level
`ifdef WR_INGRESS_DROP_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_THR =
    (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  head;
  logic                  tail;
  skid_cnt_t             count;
  skid_cnt_t             count_nxt;
  logic                  accept;
  logic                  drain;
  logic [ADDR_WIDTH:0]   wr_bin;
  logic [ADDR_WIDTH:0]   rd_bin;
  logic [ADDR_WIDTH:0]   level;

  assign Wr_en   = (count != SKID_EMPTY) & ~Wr_full;
  assign drain   = Wr_en;
  assign wr_data = mem[head];

`ifdef WR_INGRESS_DROP_EN
  logic drop;
  // A full buffer still takes a word when the head leaves this cycle.
  assign accept = in_if.in_valid & in_if.in_ready
                & ((count != SKID_FULL) | drain);
  assign drop   = in_if.in_valid & in_if.in_ready & ~accept;
`else
  assign accept = in_if.in_valid & in_if.in_ready;
`endif

  assign count_nxt = count + skid_cnt_t'(accept)
                   - skid_cnt_t'(drain);

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      count          <= SKID_EMPTY;
      head           <= 1'b0;
      tail           <= 1'b0;
      in_if.in_ready <= 1'b0;
    end else begin
      count <= count_nxt;
      if (accept) tail <= ~tail;
      if (drain)  head <= ~head;
`ifdef WR_INGRESS_DROP_EN
      in_if.in_ready <= 1'b1;
`else
      in_if.in_ready <= (count_nxt < SKID_FULL);
`endif
    end
  end

  always_ff @(posedge wr_clk) begin
    if (accept) mem[tail] <= in_if.in_data;
  end

  gray2bin #(.W(ADDR_WIDTH+1)) u_wr_g2b (
    .gray (wr_ptr),
    .bin  (wr_bin)
  );

  gray2bin #(.W(ADDR_WIDTH+1)) u_rd_g2b (
    .gray (sync_read_ptr),
    .bin  (rd_bin)
  );

  // MSB-inclusive modular difference absorbs pointer wrap.
  assign level = wr_bin - rd_bin;

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      fifo_level  <= '0;
      almost_full <= 1'b0;
    end else begin
      fifo_level  <= level;
      almost_full <= (level >= AF_THR);
    end
  end

`ifdef WR_INGRESS_DROP_EN
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Scoreboard bench for wr_ingress_ctrl with a write address generator model.
// Build with WR_INGRESS_DROP_EN to exercise the drop-mode scenario.
module tb_wr_ingress_ctrl;
  import wr_ingress_pkg::*;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam logic [AW:0] DEPTH_V = 6'd32;
  localparam int BIG = 1 << 30;

  logic          wr_clk;
  logic          reset;
  logic          Wr_full;
  logic          Wr_en;
  logic          almost_full;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   sync_read_ptr;
  logic [AW:0]   fifo_level;
  logic [DW-1:0] wr_data;
`ifdef WR_INGRESS_DROP_EN
  logic [15:0]   drop_count;
`endif

  wr_ingress_ctrl_if #(.DATA_WIDTH(DW)) in_if ();

  wr_ingress_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .AF_MARGIN  (4)
  ) dut (
    .wr_clk        (wr_clk),
    .reset         (reset),
    .in_if         (in_if),
    .Wr_full       (Wr_full),
    .wr_ptr        (wr_ptr),
    .sync_read_ptr (sync_read_ptr),
    .Wr_en         (Wr_en),
    .wr_data       (wr_data),
    .almost_full   (almost_full),
    .fifo_level    (fifo_level)
`ifdef WR_INGRESS_DROP_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] b2g(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Write address generator model
  logic        model_on;
  logic        frc_full;
  logic        gen_full;
  logic [AW:0] wbin;
  logic [AW:0] rd_bin;
  logic [AW:0] frc_wptr;
  logic [AW:0] nx_w;
  logic [AW:0] lvl_w;

  assign nx_w  = wbin + {{AW{1'b0}}, (Wr_en & ~gen_full)};
  assign lvl_w = nx_w - rd_bin;
  assign wr_ptr        = model_on ? b2g(wbin) : frc_wptr;
  assign sync_read_ptr = b2g(rd_bin);
  assign Wr_full       = model_on ? gen_full : frc_full;

  always @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      wbin     <= '0;
      gen_full <= 1'b0;
    end else if (model_on) begin
      wbin     <= nx_w;
      gen_full <= (lvl_w == DEPTH_V);
    end
  end

  // Scoreboard: push on accept, pop on write
  logic [DW-1:0] sb [$];
  int n_wr   = 0;
  int n_push = 0;
  int push_max;
  logic af_watch;

  always @(negedge wr_clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (Wr_en) begin
        n_wr <= n_wr + 1;
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check("wr_data", wr_data, sb.pop_front());
      end
      if (in_if.in_valid && in_if.in_ready) begin
        n_push <= n_push + 1;
        if (n_push < push_max) sb.push_back(in_if.in_data);
      end
      if (af_watch && fifo_level == 6'd28) check("af_at28", almost_full, 1);
      if (af_watch && fifo_level == 6'd27) check("af_at27", almost_full, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic send_words(input int n, input logic [7:0] base,
                            input int max_cyc, output int sent);
    logic acc;
    sent = 0;
    in_if.in_valid = 1'b1;
    in_if.in_data  = base;
    for (int c = 0; c < max_cyc && sent < n; c++) begin
      @(negedge wr_clk);
      acc = in_if.in_ready;
      @(posedge wr_clk);
      #1;
      if (acc) begin
        sent++;
        in_if.in_data = base + 8'(sent);
        if (sent == n) in_if.in_valid = 1'b0;
      end
    end
    in_if.in_valid = 1'b0;
  endtask

  typedef struct {
    logic [AW:0] w;
    logic [AW:0] r;
    logic [AW:0] lvl;
    logic        af;
  } lvl_vec_t;

  lvl_vec_t lvl_tab [5] = '{
    '{6'd35, 6'd5,  6'd30, 1'b1},
    '{6'd35, 6'd9,  6'd26, 1'b0},
    '{6'd40, 6'd8,  6'd32, 1'b1},
    '{6'd3,  6'd40, 6'd27, 1'b0},
    '{6'd36, 6'd8,  6'd28, 1'b1}
  };

  initial begin
    int sent;
    int found;
    int w0;
    logic [DW-1:0] d0;
    logic [DW-1:0] dv;

    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    model_on = 1'b1;
    frc_full = 1'b0;
    frc_wptr = '0;
    rd_bin   = '0;
    push_max = BIG;
    af_watch = 1'b0;
    reset    = 1'b1;

    #12;
    check("rst_wr_en", Wr_en, 0);
    check("rst_in_ready", in_if.in_ready, 0);
    check("rst_level", fifo_level, 0);
    check("rst_af", almost_full, 0);
`ifdef WR_INGRESS_DROP_EN
    check("rst_drops", drop_count, 0);
`endif
    @(negedge wr_clk);
    reset = 1'b0;
    #2;
    check("rdy_before_edge", in_if.in_ready, 0);
    @(negedge wr_clk);
    check("rdy_after_edge", in_if.in_ready, 1);
    step(1);

`ifndef WR_INGRESS_DROP_EN
    // Burst into an empty FIFO until full
    w0 = n_wr;
    af_watch = 1'b1;
    send_words(40, 8'h00, 60, sent);
    step(2);
    af_watch = 1'b0;
    check("burst_accepted", sent, 34);
    check("burst_writes", n_wr - w0, 32);
    check("burst_full", Wr_full, 1);
    check("burst_rdy", in_if.in_ready, 0);
    check("burst_head", wr_data, 8'h20);
    check("burst_sb", sb.size(), 2);
    check("burst_level", fifo_level, 32);
    check("burst_af", almost_full, 1);

    // Backpressure hold then release
    d0 = wr_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge wr_clk);
      check("hold_en", Wr_en, 0);
      check("hold_data", wr_data, d0);
    end
    step(1);
    rd_bin = 6'd2;
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      @(negedge wr_clk);
      if (Wr_en) found = 1;
    end
    check("rel_first_en", found, 1);
    @(negedge wr_clk);
    check("rel_second_en", Wr_en, 1);
    @(negedge wr_clk);
    check("rel_third_en", Wr_en, 0);
    check("rel_rdy", in_if.in_ready, 1);
    check("rel_writes", n_wr - w0, 34);
    check("rel_sb", sb.size(), 0);
    step(1);
`endif

    // Level and almost_full from forced pointers
    model_on = 1'b0;
    frc_full = 1'b1;
    foreach (lvl_tab[i]) begin
      step(1);
      frc_wptr = b2g(lvl_tab[i].w);
      rd_bin   = lvl_tab[i].r;
      @(posedge wr_clk);
      @(negedge wr_clk);
      check("level", fifo_level, lvl_tab[i].lvl);
      check("level_af", almost_full, lvl_tab[i].af);
    end
    step(1);

    // Reset with two buffered words and nonzero level
    w0 = n_wr;
    send_words(2, 8'h40, 6, sent);
    check("prerst_sent", sent, 2);
    #2;
    reset    = 1'b1;
    frc_full = 1'b0;
    #1;
    check("mid_rst_en", Wr_en, 0);
    check("mid_rst_rdy", in_if.in_ready, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_af", almost_full, 0);
    repeat (2) @(negedge wr_clk);
    reset = 1'b0;
    @(negedge wr_clk);
    check("post_rst_rdy", in_if.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge wr_clk);
      check("no_stale_en", Wr_en, 0);
    end
    check("no_stale_cnt", n_wr - w0, 0);
    step(1);

    // Streaming with one word resident
    frc_full = 1'b1;
    send_words(1, 8'h11, 4, sent);
    frc_full = 1'b0;
    dv = 8'hA5;
    in_if.in_valid = 1'b1;
    in_if.in_data  = dv;
    for (int i = 0; i < 8; i++) begin
      @(negedge wr_clk);
      check("stream_en", Wr_en, 1);
      check("stream_rdy", in_if.in_ready, 1);
      step(1);
      dv = (dv == 8'hA5) ? 8'h5A : 8'hA5;
      in_if.in_data = dv;
    end
    in_if.in_valid = 1'b0;
    step(3);
    check("stream_sb", sb.size(), 0);
    check("stream_idle", Wr_en, 0);

`ifdef WR_INGRESS_DROP_EN
    // Overflow drops while held full
    frc_full = 1'b1;
    push_max = n_push + 2;
    send_words(5, 8'h60, 8, sent);
    check("drop_sent", sent, 5);
    check("drop_rdy", in_if.in_ready, 1);
    step(1);
    check("drop_count", drop_count, 3);
    check("drop_sb", sb.size(), 2);
    frc_full = 1'b0;
    push_max = BIG;
    step(4);
    check("drop_drain", sb.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/wr_ingress_ctrl.md
Name: wr_ingress_ctrl

Overview:
Write-domain front end for the async FIFO. It sits directly upstream of the write address generator and the dual-port RAM write port. It accepts a producer valid/ready stream into a 2-entry skid buffer and drives the write-enable and write-data pair. Write-enable is qualified by the registered full flag. It also computes a registered fill level and an almost-full flag from the write gray pointer and the synchronized read gray pointer.

Parameters:
ADDR_WIDTH, 5, FIFO address bits; depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
DATA_WIDTH, 8, payload width.
AF_MARGIN, 4, almost_full asserts when level >= DEPTH-AF_MARGIN; legal range 1..DEPTH-1.

Ports:
wr_clk  in  1  write-domain clock.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  producer data valid.
in_data  in  DATA_WIDTH  producer payload.
in_ready  out  1  registered; skid buffer can accept.
Wr_full  in  1  registered full flag from the write address generator.
wr_ptr  in  ADDR_WIDTH+1  write gray pointer from the write address generator.
sync_read_ptr  in  ADDR_WIDTH+1  read gray pointer, already 2-flop synchronized into wr_clk.
Wr_en  out  1  write request to the address generator and RAM.
wr_data  out  DATA_WIDTH  RAM write data (skid head).
almost_full  out  1  registered almost-full flag.
fifo_level  out  ADDR_WIDTH+1  registered occupancy estimate, 0..DEPTH.
drop_count  out  16  present only with WR_INGRESS_DROP_EN.

Behaviour:
- Reset is asynchronous, active-high, on wr_clk. All of the following clear to 0: in_ready, almost_full, fifo_level, skid count, head/tail index, and drop_count. While reset is asserted, Wr_en is 0.
- in_ready rises on the first wr_clk edge after reset deasserts.
- Skid buffer: 2 entries, in-order, count 0..2.
  - Accept: in_valid & in_ready.
  - Drain: Wr_en.
- Wr_en = (count != 0) & ~Wr_full. This is combinational from registered state only.
- wr_data = head entry. It holds stable while Wr_en is low.
- in_ready_next = (count_next < 2). in_ready is registered, so it never combinationally depends on in_valid.
- Latency: a word accepted at edge N can appear on Wr_en/wr_data in the cycle following edge N, at the earliest.
- Simultaneous accept and drain: count is unchanged, order is preserved, and pointers advance independently.
- Wr_full asserts one cycle after the filling write. Because Wr_en is gated by the registered Wr_full, a word is never lost: the address generator ignores Wr_en while Wr_full is high, and this block never asserts Wr_en in that case.
- Level: level = gray2bin(wr_ptr) - gray2bin(sync_read_ptr), computed modulo 2**(ADDR_WIDTH+1).
  - Registered into fifo_level each cycle.
  - almost_full is registered as (level >= DEPTH-AF_MARGIN).
  - Both outputs are one cycle behind the pointer inputs.
  - Because sync_read_ptr lags, level is an overestimate. This is conservative and acceptable.
- Wrap-around: the MSB-inclusive subtraction handles pointer wrap. Level exactly DEPTH is legal (full).
- Reset mid-operation: buffered words are discarded. This is intended because the pointers reset simultaneously.

Optional Feature:
WR_INGRESS_DROP_EN.
- Defined:
  - in_ready is tied to 1 after reset.
  - A valid word arriving while count==2 and no drain occurs that cycle is dropped, and drop_count increments.
  - drop_count saturates at 16'hFFFF.
  - The drop_count port exists.
- Undefined:
  - The backpressure behaviour above applies.
  - No drop_count port or counter.

Decomposition:
- Package wr_ingress_pkg holds:
  - Default ADDR_WIDTH and DATA_WIDTH constants.
  - DROP_CNT_W=16.
  - The skid count encoding (2-bit, values 0..2).
- Sub-module gray2bin is parameterized by width as pure combinational XOR-prefix logic. It is instantiated twice, once for wr_ptr and once for sync_read_ptr.

Test Plan:
All scenarios use ADDR_WIDTH=5, DATA_WIDTH=8, AF_MARGIN=4.
1. Reset: assert reset mid-stream with count=2 -> immediately Wr_en=0, in_ready=0, fifo_level=0, almost_full=0; release -> in_ready=1 the next cycle, and no stale word is written.
2. Burst of 40 words, in_valid constantly high, sync_read_ptr=0, driven by a write address generator model -> exactly 32 Wr_en pulses carrying data 0x00..0x1F in order. Wr_full rises after the 32nd write. Words 0x20 and 0x21 are held in the skid buffer, then in_ready=0. almost_full=1 once fifo_level reaches 28.
3. Backpressure hold: Wr_full=1 with count=2 for 10 cycles -> Wr_en=0 and wr_data constant. Release Wr_full -> 2 Wr_en pulses in consecutive cycles, then in_ready returns to 1.
4. Level wrap: wr_ptr=gray(6'd35), sync_read_ptr=gray(6'd5) -> fifo_level=30 and almost_full=1 one cycle later. Change sync_read_ptr to gray(6'd9) -> level=26, almost_full=0.
5. Simultaneous accept and drain at count=1, alternating data 0xA5/0x5A -> count stays 1 and output order matches input order.
6. With WR_INGRESS_DROP_EN: hold Wr_full=1 and send 5 words -> 2 buffered, drop_count=3, in_ready stays 1.
